// File: rtl/mux93_arb_pkg.sv
// Shared types, sizes and helpers for the 9-source round-robin arbiter
// that drives the one-hot select of the 24-bit pixel selector.
package mux93_arb_pkg;

   localparam int N_SRC = 9;
   localparam int ID_W  = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Out-of-range indices map to all-zero so the selector can never see a stray bit.
   function automatic logic [N_SRC-1:0] idx_to_onehot(input logic [ID_W-1:0] idx);
      logic [N_SRC-1:0] oh;
      oh = '0;
      if (idx < ID_W'(N_SRC)) begin
         oh[idx] = 1'b1;
      end else begin
         oh = '0;
      end
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick9.sv
// Combinational round-robin picker: finds the first set bit of req & ~mask
// at or after ptr, wrapping from source 8 back to source 0.
module rr_pick9
   import mux93_arb_pkg::*;
(
   input  logic [N_SRC-1:0] req,
   input  logic [N_SRC-1:0] mask,
   input  logic [ID_W-1:0]  ptr,
   output logic             found,
   output logic [ID_W-1:0]  idx
);

   localparam int PW = ID_W + 1;

   logic [N_SRC-1:0] cand;
   logic [ID_W-1:0]  start;
   logic [PW-1:0]    sum;
   logic [PW-1:0]    pos;
   logic             hit;

   assign cand  = req & ~mask;
   assign start = (ptr < ID_W'(N_SRC)) ? ptr : '0;

   // Walk from the farthest position back to start so the nearest candidate is kept last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      sum   = '0;
      pos   = '0;
      hit   = 1'b0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         sum   = {1'b0, start} + PW'(k);
         pos   = (sum >= PW'(N_SRC)) ? (sum - PW'(N_SRC)) : sum;
         hit   = cand[pos[ID_W-1:0]];
         found = found | hit;
         idx   = hit ? pos[ID_W-1:0] : idx;
      end
   end

endmodule

// File: rtl/mux93_arbiter.sv
// Round-robin arbiter and burst sequencer for the 9-way one-hot pixel selector,
// with zero-bubble hand-off between bursts and abort on a dropped request.
module mux93_arbiter
   import mux93_arb_pkg::*;
#(
   parameter int MAX_BEATS = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] req,
   input  logic [N_SRC-1:0] last,
   output logic [N_SRC-1:0] sel,
   output logic [ID_W-1:0]  gnt_id,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_SRC-1:0] ack,
   output logic             abort
);

   localparam int               CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BEATS - 1);

   arb_state_t       state_q;
   logic [N_SRC-1:0] sel_q;
   logic [ID_W-1:0]  gnt_id_q;
   logic [ID_W-1:0]  ptr_q;
   logic [ID_W-1:0]  ptr_d;
   logic [CNT_W-1:0] beat_cnt_q;

   logic             granted;
   logic             cur_req;
   logic             cur_last;
   logic             accept;
   logic             at_max;
   logic             rel_now;
   logic [N_SRC-1:0] pick_mask;
   logic [ID_W-1:0]  pick_ptr;
   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;

   assign sel    = sel_q;
   assign gnt_id = gnt_id_q;

   // Handshake, release decision and picker steering; the picker masks the owner during hand-off.
   always_comb begin
      granted   = (state_q == GRANT);
      cur_req   = req[gnt_id_q];
      cur_last  = last[gnt_id_q];
      out_valid = granted & cur_req;
      accept    = out_valid & out_ready;
      abort     = granted & ~cur_req;
      ack       = accept ? sel_q : '0;
      at_max    = (beat_cnt_q == BEAT_LAST);
      rel_now   = abort | (accept & (cur_last | at_max));
      ptr_d     = (gnt_id_q >= ID_W'(N_SRC - 1)) ? '0 : (gnt_id_q + ID_W'(1));
      pick_mask = granted ? sel_q : '0;
      pick_ptr  = granted ? ptr_d : ptr_q;
   end

   rr_pick9 u_pick (
      .req   (req),
      .mask  (pick_mask),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Arbitration FSM: load a winner from IDLE, count beats and hand off on release in GRANT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         gnt_id_q   <= '0;
         ptr_q      <= '0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_q    <= GRANT;
                  sel_q      <= idx_to_onehot(pick_idx);
                  gnt_id_q   <= pick_idx;
                  beat_cnt_q <= '0;
               end
            end
            GRANT: begin
               if (rel_now) begin
                  ptr_q      <= ptr_d;
                  beat_cnt_q <= '0;
                  if (pick_found) begin
                     sel_q    <= idx_to_onehot(pick_idx);
                     gnt_id_q <= pick_idx;
                  end else begin
                     state_q  <= IDLE;
                     sel_q    <= '0;
                     gnt_id_q <= '0;
                  end
               end else if (accept) begin
                  beat_cnt_q <= beat_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q    <= IDLE;
               sel_q      <= '0;
               gnt_id_q   <= '0;
               beat_cnt_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux93_arbiter.sv
// Randomized and directed bench for mux93_arbiter: two instances (MAX_BEATS 4 and 1)
// share stimulus and are each compared every cycle against a behavioural model.
module tb_mux93_arbiter;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [8:0]     req;
   logic [8:0]     last;
   logic           out_ready;

   logic [1:0][8:0] sel_w;
   logic [1:0][8:0] ack_w;
   logic [1:0][3:0] gnt_w;
   logic [1:0]      vld_w;
   logic [1:0]      abt_w;

   int n_checks = 0;
   int n_errors = 0;

   // Model state per instance: owner (-1 when idle), beats accepted so far, pointer, beat limit.
   int m_own   [2];
   int m_beats [2];
   int m_ptr   [2];
   int m_max   [2];

   logic [8:0] rr;
   logic [8:0] rl;

   always #5 clk = ~clk;

   mux93_arbiter #(.MAX_BEATS(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last),
      .sel(sel_w[0]), .gnt_id(gnt_w[0]), .out_valid(vld_w[0]),
      .out_ready(out_ready), .ack(ack_w[0]), .abort(abt_w[0])
   );

   mux93_arbiter #(.MAX_BEATS(1)) dut_b1 (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last),
      .sel(sel_w[1]), .gnt_id(gnt_w[1]), .out_valid(vld_w[1]),
      .out_ready(out_ready), .ack(ack_w[1]), .abort(abt_w[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, check outputs against the model, then advance the model.
   task automatic step(input logic [8:0] r, input logic [8:0] l, input logic rdy);
      @(negedge clk);
      req = r;
      last = l;
      out_ready = rdy;
      #1;
      for (int d = 0; d < 2; d++) begin
         int         o;
         int         c;
         logic       own_req;
         logic       e_acc;
         logic       e_ab;
         logic [8:0] e_sel;
         o       = m_own[d];
         own_req = (o >= 0) ? r[o] : 1'b0;
         e_sel   = (o >= 0) ? (9'd1 << o) : 9'd0;
         e_acc   = own_req && rdy;
         e_ab    = (o >= 0) && !own_req;
         chk($sformatf("sel%0d", d),   32'(sel_w[d]), 32'(e_sel));
         chk($sformatf("gnt%0d", d),   32'(gnt_w[d]), (o >= 0) ? o : 0);
         chk($sformatf("valid%0d", d), 32'(vld_w[d]), 32'(own_req));
         chk($sformatf("ack%0d", d),   32'(ack_w[d]), e_acc ? 32'(e_sel) : 32'd0);
         chk($sformatf("abort%0d", d), 32'(abt_w[d]), 32'(e_ab));
         if (o < 0) begin
            for (int k = 8; k >= 0; k--) begin
               c = (m_ptr[d] + k) % 9;
               if (r[c]) begin
                  m_own[d]   = c;
                  m_beats[d] = 0;
               end
            end
         end else if (e_ab || (e_acc && (l[o] || (m_beats[d] + 1 >= m_max[d])))) begin
            m_ptr[d]   = (o + 1) % 9;
            m_own[d]   = -1;
            m_beats[d] = 0;
            for (int k = 8; k >= 0; k--) begin
               c = (m_ptr[d] + k) % 9;
               if (c != o && r[c]) m_own[d] = c;
            end
         end else if (e_acc) begin
            m_beats[d]++;
         end
      end
   endtask

   // Assert reset between clock edges, check outputs clear at once, then release with req idle.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_sel%0d", d),   32'(sel_w[d]), 32'd0);
         chk($sformatf("rst_gnt%0d", d),   32'(gnt_w[d]), 32'd0);
         chk($sformatf("rst_valid%0d", d), 32'(vld_w[d]), 32'd0);
         chk($sformatf("rst_ack%0d", d),   32'(ack_w[d]), 32'd0);
         chk($sformatf("rst_abort%0d", d), 32'(abt_w[d]), 32'd0);
         m_own[d]   = -1;
         m_beats[d] = 0;
         m_ptr[d]   = 0;
      end
      repeat (2) @(negedge clk);
      req   = 9'h000;
      last  = 9'h000;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = 9'h000;
      last      = 9'h000;
      out_ready = 1'b0;
      m_max[0]  = 4;
      m_max[1]  = 1;
      do_reset();

      // Single source, three-word burst ending on last, then pointer should sit at 3.
      step(9'h004, 9'h000, 1'b1);
      step(9'h004, 9'h000, 1'b1);
      step(9'h004, 9'h000, 1'b1);
      step(9'h004, 9'h004, 1'b1);
      step(9'h000, 9'h000, 1'b1);
      step(9'h009, 9'h000, 1'b1);
      step(9'h009, 9'h009, 1'b1);
      step(9'h009, 9'h009, 1'b1);
      step(9'h000, 9'h000, 1'b1);

      // All requesting, one word each: full rotation with no bubbles.
      repeat (12) step(9'h1FF, 9'h1FF, 1'b1);

      // Two sources without last: forced rotation at the beat limit.
      repeat (14) step(9'h003, 9'h000, 1'b1);
      repeat (2)  step(9'h000, 9'h000, 1'b1);

      // Source 5 stalled by downstream for ten cycles.
      step(9'h020, 9'h000, 1'b1);
      repeat (10) step(9'h020, 9'h000, 1'b0);
      step(9'h020, 9'h020, 1'b1);
      step(9'h000, 9'h000, 1'b1);

      // Source 7 drops its request mid-burst while others wait.
      step(9'h080, 9'h000, 1'b0);
      step(9'h080, 9'h000, 1'b1);
      step(9'h091, 9'h000, 1'b1);
      step(9'h011, 9'h000, 1'b1);
      step(9'h011, 9'h000, 1'b1);
      step(9'h000, 9'h000, 1'b1);

      // Reset in the middle of a burst, then arbitration restarts from source 0.
      repeat (3) step(9'h1FF, 9'h000, 1'b1);
      do_reset();
      repeat (3) step(9'h1FF, 9'h000, 1'b1);

      // Random traffic with slowly changing requests.
      rr = 9'h000;
      for (int n = 0; n < 400; n++) begin
         for (int b = 0; b < 9; b++) begin
            if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
         end
         rl = 9'($urandom & $urandom);
         step(rr, rl, ($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 99) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
